// File: rtl/proc_io_bridge_pkg.sv
// Shared types and width helpers for the processor I/O bridge and its FIFOs.
package proc_io_bridge_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    FIRED = 1'b1
  } itr_state_e;

  // Clamp to one bit so single-entry counts still yield a legal vector width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/proc_io_bridge_io_fifo.sv
// Single-clock circular FIFO; a push into a full FIFO is accepted only when a pop frees a slot the same cycle.
module io_fifo
  import proc_io_bridge_pkg::*;
#(
  parameter int NBDATA = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [NBDATA-1:0] din,
  input  logic              pop,
  output logic [NBDATA-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [NBDATA-1:0] mem_q [DEPTH];
  logic [PW-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the cleared count hides stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/proc_io_bridge.sv
// Buffered I/O bridge: per-address input/output FIFOs, sticky error flags and an arrival interrupt.
module proc_io_bridge
  import proc_io_bridge_pkg::*;
#(
  parameter int                NUBITS = 16,
  parameter int                NUIOIN = 2,
  parameter int                NUIOOU = 2,
  parameter int                IODPTH = 4,
  parameter logic [NUIOIN-1:0] ITRMSK = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUBITS-1:0]            p_io_out,
  input  logic [idx_width(NUIOOU)-1:0] p_addr_out,
  input  logic                         p_out_en,
  output logic [NUBITS-1:0]            p_io_in,
  input  logic [idx_width(NUIOIN)-1:0] p_addr_in,
  input  logic                         p_req_in,
  output logic                         p_itr,
  input  logic [NUIOIN*NUBITS-1:0]     ext_in_data,
  input  logic [NUIOIN-1:0]            ext_in_valid,
  output logic [NUIOIN-1:0]            ext_in_ready,
  output logic [NUIOOU*NUBITS-1:0]     ext_out_data,
  output logic [NUIOOU-1:0]            ext_out_valid,
  input  logic [NUIOOU-1:0]            ext_out_ready,
  output logic [NUIOOU-1:0]            ovf_flags,
  output logic [NUIOIN-1:0]            udf_flags,
  input  logic                         clr_flags
);

  localparam int AIW = idx_width(NUIOIN);
  localparam int AOW = idx_width(NUIOOU);

  logic [NUIOIN-1:0] in_pop, in_full, in_empty;
  logic [NUBITS-1:0] in_dout [NUIOIN];
  logic [NUIOOU-1:0] out_push, out_pop, out_full, out_empty;

  logic [NUIOOU-1:0] ovf_q, ovf_d;
  logic [NUIOIN-1:0] udf_q, udf_d;
  itr_state_e        state_q, state_d;
  logic              itr_q, itr_d;
  logic              pend;

  // Out-of-range addresses match no channel, so they neither pop nor flag.
  for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_in
    assign in_pop[gi]       = p_req_in && (p_addr_in == AIW'(gi));
    assign ext_in_ready[gi] = ~in_full[gi];
    io_fifo #(.NBDATA(NUBITS), .DEPTH(IODPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ext_in_valid[gi]),
      .din   (ext_in_data[gi*NUBITS +: NUBITS]),
      .pop   (in_pop[gi]),
      .dout  (in_dout[gi]),
      .full  (in_full[gi]),
      .empty (in_empty[gi])
    );
  end

  for (genvar go = 0; go < NUIOOU; go++) begin : g_out
    assign out_push[go]      = p_out_en && (p_addr_out == AOW'(go));
    assign out_pop[go]       = ext_out_ready[go] & ~out_empty[go];
    assign ext_out_valid[go] = ~out_empty[go];
    io_fifo #(.NBDATA(NUBITS), .DEPTH(IODPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (out_push[go]),
      .din   (p_io_out),
      .pop   (out_pop[go]),
      .dout  (ext_out_data[go*NUBITS +: NUBITS]),
      .full  (out_full[go]),
      .empty (out_empty[go])
    );
  end

  always_comb begin
    p_io_in = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if ((p_addr_in == AIW'(i)) && !in_empty[i]) p_io_in = in_dout[i];
    end
  end

  // Set events are OR-ed after the clear so they win over clr_flags.
  always_comb begin
    udf_d = (clr_flags ? '0 : udf_q) | (in_pop & in_empty);
    ovf_d = (clr_flags ? '0 : ovf_q) | (out_push & out_full & ~out_pop);
  end

  assign pend = |(~in_empty & ITRMSK);

  // ARMED: waiting for a masked channel to hold data | FIRED: pulse sent, waiting for all masked channels to drain
  always_comb begin
    state_d = state_q;
    itr_d   = 1'b0;
    case (state_q)
      ARMED: begin
        if (pend) begin
          itr_d   = 1'b1;
          state_d = FIRED;
        end
      end
      FIRED: begin
        if (!pend) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q   <= '0;
      udf_q   <= '0;
      state_q <= ARMED;
      itr_q   <= 1'b0;
    end else begin
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      state_q <= state_d;
      itr_q   <= itr_d;
    end
  end

  assign ovf_flags = ovf_q;
  assign udf_flags = udf_q;
  assign p_itr     = itr_q;

endmodule

// File: tb/tb_proc_io_bridge.sv
// Directed and random stimulus for proc_io_bridge, checked against a queue-based reference model.
module tb_proc_io_bridge;

  localparam int                NUBITS = 16;
  localparam int                NUIOIN = 2;
  localparam int                NUIOOU = 2;
  localparam int                IODPTH = 4;
  localparam logic [NUIOIN-1:0] ITRMSK = 2'b01;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUBITS-1:0]        p_io_out;
  logic [0:0]               p_addr_out;
  logic                     p_out_en;
  logic [NUBITS-1:0]        p_io_in;
  logic [0:0]               p_addr_in;
  logic                     p_req_in;
  logic                     p_itr;
  logic [NUIOIN*NUBITS-1:0] ext_in_data;
  logic [NUIOIN-1:0]        ext_in_valid;
  logic [NUIOIN-1:0]        ext_in_ready;
  logic [NUIOOU*NUBITS-1:0] ext_out_data;
  logic [NUIOOU-1:0]        ext_out_valid;
  logic [NUIOOU-1:0]        ext_out_ready;
  logic [NUIOOU-1:0]        ovf_flags;
  logic [NUIOIN-1:0]        udf_flags;
  logic                     clr_flags;

  always #5 clk = ~clk;

  proc_io_bridge #(
    .NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .IODPTH(IODPTH), .ITRMSK(ITRMSK)
  ) dut (
    .clk(clk), .rst(rst),
    .p_io_out(p_io_out), .p_addr_out(p_addr_out), .p_out_en(p_out_en),
    .p_io_in(p_io_in), .p_addr_in(p_addr_in), .p_req_in(p_req_in), .p_itr(p_itr),
    .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
    .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
    .ovf_flags(ovf_flags), .udf_flags(udf_flags), .clr_flags(clr_flags)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  logic [NUBITS-1:0] in_q  [NUIOIN][$];
  logic [NUBITS-1:0] out_q [NUIOOU][$];
  logic [NUIOOU-1:0] m_ovf;
  logic [NUIOIN-1:0] m_udf;
  logic              m_itr;
  logic              m_pend_prev;
  logic [NUIOIN-1:0] mask;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUIOIN; i++) in_q[i].delete();
    for (int j = 0; j < NUIOOU; j++) out_q[j].delete();
    m_ovf = '0;
    m_udf = '0;
    m_itr = 1'b0;
    m_pend_prev = 1'b0;
  endtask

  task automatic check_outputs();
    logic [NUIOIN-1:0] e_rdy;
    logic [NUIOOU-1:0] e_vld;
    logic [NUBITS-1:0] e_io;
    for (int i = 0; i < NUIOIN; i++) e_rdy[i] = (in_q[i].size() < IODPTH);
    for (int j = 0; j < NUIOOU; j++) e_vld[j] = (out_q[j].size() > 0);
    e_io = '0;
    if (int'(p_addr_in) < NUIOIN && in_q[p_addr_in].size() > 0) e_io = in_q[p_addr_in][0];
    check("in_ready", 64'(ext_in_ready), 64'(e_rdy));
    check("out_valid", 64'(ext_out_valid), 64'(e_vld));
    check("p_io_in", 64'(p_io_in), 64'(e_io));
    check("p_itr", 64'(p_itr), 64'(m_itr));
    check("ovf_flags", 64'(ovf_flags), 64'(m_ovf));
    check("udf_flags", 64'(udf_flags), 64'(m_udf));
    for (int j = 0; j < NUIOOU; j++)
      if (out_q[j].size() > 0)
        check("out_data", 64'(ext_out_data[j*NUBITS +: NUBITS]), 64'(out_q[j][0]));
  endtask

  // Applies the current inputs to the model as one clock edge.
  task automatic model_update();
    logic pend;
    int   sz;
    logic pop, had;
    pend = 1'b0;
    for (int i = 0; i < NUIOIN; i++) if (mask[i] && in_q[i].size() > 0) pend = 1'b1;
    // Interrupt is a registered rising edge of "some masked channel holds data".
    m_itr = pend && !m_pend_prev;
    m_pend_prev = pend;
    if (clr_flags) begin
      m_ovf = '0;
      m_udf = '0;
    end
    for (int i = 0; i < NUIOIN; i++) begin
      sz  = in_q[i].size();
      pop = p_req_in && (int'(p_addr_in) == i);
      had = (sz > 0);
      if (pop && had) void'(in_q[i].pop_front());
      if (pop && !had) m_udf[i] = 1'b1;
      if (ext_in_valid[i] && (sz < IODPTH || (pop && had)))
        in_q[i].push_back(ext_in_data[i*NUBITS +: NUBITS]);
    end
    for (int j = 0; j < NUIOOU; j++) begin
      sz  = out_q[j].size();
      pop = ext_out_ready[j] && (sz > 0);
      if (pop) void'(out_q[j].pop_front());
      if (p_out_en && int'(p_addr_out) == j) begin
        if (sz < IODPTH || pop) out_q[j].push_back(p_io_out);
        else m_ovf[j] = 1'b1;
      end
    end
  endtask

  task automatic step();
    #1;
    check_outputs();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_idle();
    ext_in_valid  = '0;
    ext_in_data   = '0;
    ext_out_ready = '0;
    p_out_en      = 1'b0;
    p_io_out      = '0;
    p_addr_out    = '0;
    p_req_in      = 1'b0;
    p_addr_in     = '0;
    clr_flags     = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    mask = ITRMSK;
    rst  = 1'b1;
    drive_idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", 64'(ext_in_ready), 64'h3);
    check("rst_out_valid", 64'(ext_out_valid), 64'h0);
    check("rst_p_io_in", 64'(p_io_in), 64'h0);
    check("rst_p_itr", 64'(p_itr), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    step();

    // Output fill past depth, then drain.
    for (int k = 0; k < 5; k++) begin
      p_out_en = 1'b1; p_addr_out = 1'b1; p_io_out = NUBITS'(16'h0011 + k);
      step();
    end
    drive_idle();
    #1;
    check("fill_ovf", 64'(ovf_flags), 64'h2);
    check("fill_valid", 64'(ext_out_valid), 64'h2);
    ext_out_ready = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("drain_data", 64'(ext_out_data[NUBITS +: NUBITS]), 64'(16'h0011 + k));
      check("drain_valid", 64'(ext_out_valid[1]), 64'h1);
      step();
    end
    #1;
    check("drain_empty", 64'(ext_out_valid), 64'h0);
    drive_idle();
    clr_flags = 1'b1;
    step();
    drive_idle();

    // Input read then underflow.
    ext_in_valid = 2'b01; ext_in_data = {16'h0000, 16'hBEEF};
    step();
    drive_idle();
    #1;
    check("rd_head", 64'(p_io_in), 64'hBEEF);
    p_req_in = 1'b1;
    step();
    p_req_in = 1'b0;
    #1;
    check("rd_after_pop", 64'(p_io_in), 64'h0);
    p_req_in = 1'b1;
    step();
    p_req_in = 1'b0;
    #1;
    check("udf_set", 64'(udf_flags), 64'h1);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    #1;
    check("udf_clr", 64'(udf_flags), 64'h0);

    // Channel 1 full with simultaneous push and pop.
    for (int k = 0; k < 4; k++) begin
      ext_in_valid = 2'b10; ext_in_data = {NUBITS'(16'h0100 + k), 16'h0000};
      step();
    end
    drive_idle();
    p_addr_in = 1'b1;
    #1;
    check("full_ready", 64'(ext_in_ready[1]), 64'h0);
    check("full_head", 64'(p_io_in), 64'h0100);
    p_req_in = 1'b1; ext_in_valid = 2'b10; ext_in_data = {16'h000A, 16'h0000};
    step();
    drive_idle();
    p_addr_in = 1'b1;
    #1;
    check("pp_ready", 64'(ext_in_ready[1]), 64'h0);
    check("pp_head", 64'(p_io_in), 64'h0101);
    for (int k = 0; k < 4; k++) begin
      p_addr_in = 1'b1; p_req_in = 1'b1;
      #1;
      check("pp_order", 64'(p_io_in), (k == 3) ? 64'h000A : 64'(16'h0101 + k));
      step();
    end
    drive_idle();
    step();

    // Interrupt behaviour with only channel 0 enabled.
    ext_in_valid = 2'b10; ext_in_data = {16'h5555, 16'h0000};
    step();
    drive_idle();
    step();
    step();
    #1;
    check("itr_ch1_quiet", 64'(p_itr), 64'h0);
    ext_in_valid = 2'b01; ext_in_data = {16'h0000, 16'h1234};
    step();
    drive_idle();
    step();
    #1;
    check("itr_pulse", 64'(p_itr), 64'h1);
    step();
    #1;
    check("itr_one_cycle", 64'(p_itr), 64'h0);
    ext_in_valid = 2'b01; ext_in_data = {16'h0000, 16'h4321};
    step();
    drive_idle();
    step();
    #1;
    check("itr_no_refire", 64'(p_itr), 64'h0);
    for (int k = 0; k < 2; k++) begin
      p_addr_in = 1'b0; p_req_in = 1'b1;
      step();
    end
    drive_idle();
    step();
    ext_in_valid = 2'b01; ext_in_data = {16'h0000, 16'h7777};
    step();
    drive_idle();
    step();
    #1;
    check("itr_refire", 64'(p_itr), 64'h1);
    step();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      ext_in_valid  = NUIOIN'($urandom_range(0, 3));
      ext_in_data   = {NUBITS'($urandom), NUBITS'($urandom)};
      ext_out_ready = NUIOOU'($urandom_range(0, 3));
      p_out_en      = ($urandom_range(0, 1) == 1);
      p_addr_out    = 1'($urandom_range(0, 1));
      p_io_out      = NUBITS'($urandom);
      p_req_in      = ($urandom_range(0, 1) == 1);
      p_addr_in     = 1'($urandom_range(0, 1));
      clr_flags     = ($urandom_range(0, 15) == 0);
      step();
    end

    // Async reset between edges with FIFOs partly full.
    drive_idle();
    for (int k = 0; k < 2; k++) begin
      ext_in_valid = 2'b11; ext_in_data = {16'hAAAA, 16'hBBBB};
      p_out_en = 1'b1; p_addr_out = 1'(k); p_io_out = 16'hCCCC;
      step();
    end
    drive_idle();
    p_req_in = 1'b1; p_addr_in = 1'b1;
    step();
    step();
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    check("arst_in_ready", 64'(ext_in_ready), 64'h3);
    check("arst_out_valid", 64'(ext_out_valid), 64'h0);
    check("arst_p_io_in", 64'(p_io_in), 64'h0);
    check("arst_p_itr", 64'(p_itr), 64'h0);
    check("arst_flags", 64'({ovf_flags, udf_flags}), 64'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p_addr_in = 1'(k);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
